pipe_stage_elastic: RTL and testbench

Parametrised, elastic pipeline-stage register for the five-stage MIPS core, replacing the fixed always-advance stage latches (e.g. MEM→WB). Carries PC, PC+4, PC+8, instruction and NUM_LANES generic DATA_W data lanes (ALU result, rt, load data, ext, mul/div result, …) with a valid/ready handshake, a one-entry skid buffer for back-pressure, synchronous flush, and a saturating bubble counter. Sits between any two stages; upstream stalls when downstream back-pressures.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_bundle_reg.sv | 59 +++++
 rtl/pipe_stage_elastic.sv | 146 ++++++++++++++
 tb/tb_pipe_stage_elastic.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage registers of the MIPS core.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    // Value the PC outputs take out of reset (boot vector of the core).
    localparam logic [PC_W-1:0]    PC_RESET_DEFAULT = 32'h0000_3000;

    // Instruction word presented while a stage holds no bundle (sll $0,$0,0).
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0;

endpackage

// File: rtl/pipe_bundle_reg.sv
// Payload register for one pipeline bundle (pc, pc4, pc8, instr, data lanes).
// Latency: 1 cycle from load to q_*.
// Backpressure: none; the parent decides when to load or clear.
// Ports: clk/reset (sync, active-high); load captures all d_* fields;
//        clr_instr (when not loading) overwrites only the instruction with a nop;
//        q_* are the registered fields.
module pipe_bundle_reg
    import pipe_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              NUM_LANES = 5,
    parameter logic [PC_W-1:0] PC_RESET  = PC_RESET_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          clr_instr,
    input  logic [PC_W-1:0]               d_pc,
    input  logic [PC_W-1:0]               d_pc4,
    input  logic [PC_W-1:0]               d_pc8,
    input  logic [INSTR_W-1:0]            d_instr,
    input  logic [NUM_LANES*DATA_W-1:0]   d_data,
    output logic [PC_W-1:0]               q_pc,
    output logic [PC_W-1:0]               q_pc4,
    output logic [PC_W-1:0]               q_pc8,
    output logic [INSTR_W-1:0]            q_instr,
    output logic [NUM_LANES*DATA_W-1:0]   q_data
);

    logic [PC_W-1:0]             pc_q, pc4_q, pc8_q;
    logic [INSTR_W-1:0]          instr_q;
    logic [NUM_LANES*DATA_W-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            pc4_q   <= PC_RESET;
            pc8_q   <= PC_RESET;
            instr_q <= NOP_INSTR;
            data_q  <= '0;
        end else if (load) begin
            pc_q    <= d_pc;
            pc4_q   <= d_pc4;
            pc8_q   <= d_pc8;
            instr_q <= d_instr;
            data_q  <= d_data;
        end else if (clr_instr) begin
            // PC and data keep their last values; only the instruction is killed.
            instr_q <= NOP_INSTR;
        end
    end

    assign q_pc    = pc_q;
    assign q_pc4   = pc4_q;
    assign q_pc8   = pc8_q;
    assign q_instr = instr_q;
    assign q_data  = data_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: main entry drives outputs, skid entry absorbs one bundle.
// Latency: 1 cycle input->output when unstalled, 1 bundle/cycle throughput.
// Backpressure: in_ready is a flop (= skid empty); drops the cycle after the skid fills.
// Ports: clk/reset (sync, active-high), flush (sync kill), in_* upstream bundle with
//        in_valid/in_ready, out_* registered bundle with out_valid/out_ready,
//        bubble_cnt = saturating count of cycles with out_valid low.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int              DATA_W    = 32,
    parameter int              NUM_LANES = 5,
    parameter logic [PC_W-1:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter int              CNT_W     = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [PC_W-1:0]               in_pc,
    input  logic [PC_W-1:0]               in_pc4,
    input  logic [PC_W-1:0]               in_pc8,
    input  logic [INSTR_W-1:0]            in_instr,
    input  logic [NUM_LANES*DATA_W-1:0]   in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PC_W-1:0]               out_pc,
    output logic [PC_W-1:0]               out_pc4,
    output logic [PC_W-1:0]               out_pc8,
    output logic [INSTR_W-1:0]            out_instr,
    output logic [NUM_LANES*DATA_W-1:0]   out_data,
    output logic [CNT_W-1:0]              bubble_cnt
);

    logic main_valid_q, main_valid_d;
    logic skid_valid_q, skid_valid_d;
    logic in_ready_q;
    logic [CNT_W-1:0] bubble_q;

    logic in_fire, out_fire, main_take;
    logic main_load, main_from_skid, main_clr, skid_load;

    logic [PC_W-1:0]             skid_pc, skid_pc4, skid_pc8;
    logic [INSTR_W-1:0]          skid_instr;
    logic [NUM_LANES*DATA_W-1:0] skid_data;

    assign in_fire   = in_valid && in_ready_q;
    assign out_fire  = main_valid_q && out_ready;
    // Main can be written when it is empty or its bundle leaves this cycle.
    assign main_take = !main_valid_q || out_fire;

    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        main_clr       = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_clr     = 1'b1;
        end else if (main_take) begin
            if (skid_valid_q) begin
                // Oldest bundle first: skid moves forward before any new input.
                main_load      = 1'b1;
                main_from_skid = 1'b1;
                main_valid_d   = 1'b1;
                skid_load      = in_fire;
                skid_valid_d   = in_fire;
            end else if (in_fire) begin
                main_load    = 1'b1;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
                main_clr     = 1'b1;
            end
        end else if (in_fire) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            bubble_q     <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            // Counts the pre-edge output state, independent of flush.
            if (!main_valid_q && (bubble_q != {CNT_W{1'b1}}))
                bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    pipe_bundle_reg #(
        .DATA_W   (DATA_W),
        .NUM_LANES(NUM_LANES),
        .PC_RESET (PC_RESET)
    ) u_main (
        .clk      (clk),
        .reset    (reset),
        .load     (main_load),
        .clr_instr(main_clr),
        .d_pc     (main_from_skid ? skid_pc    : in_pc),
        .d_pc4    (main_from_skid ? skid_pc4   : in_pc4),
        .d_pc8    (main_from_skid ? skid_pc8   : in_pc8),
        .d_instr  (main_from_skid ? skid_instr : in_instr),
        .d_data   (main_from_skid ? skid_data  : in_data),
        .q_pc     (out_pc),
        .q_pc4    (out_pc4),
        .q_pc8    (out_pc8),
        .q_instr  (out_instr),
        .q_data   (out_data)
    );

    pipe_bundle_reg #(
        .DATA_W   (DATA_W),
        .NUM_LANES(NUM_LANES),
        .PC_RESET (PC_RESET)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .clr_instr(1'b0),
        .d_pc     (in_pc),
        .d_pc4    (in_pc4),
        .d_pc8    (in_pc8),
        .d_instr  (in_instr),
        .d_data   (in_data),
        .q_pc     (skid_pc),
        .q_pc4    (skid_pc4),
        .q_pc8    (skid_pc8),
        .q_instr  (skid_instr),
        .q_data   (skid_data)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = main_valid_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
`timescale 1ns/1ps
// Randomised bench for pipe_stage_elastic: stage modelled as an ordered queue of
// at most two bundles; a negedge monitor pops and compares every output transfer.
module tb_pipe_stage_elastic;

    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 5;
    localparam int DW        = DATA_W * NUM_LANES;
    localparam logic [31:0] PCR = 32'h0000_3000;

    typedef struct {
        logic [31:0]   pc, pc4, pc8, instr;
        logic [DW-1:0] data;
    } bundle_t;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [31:0]   in_pc, in_pc4, in_pc8, in_instr;
    logic [31:0]   out_pc, out_pc4, out_pc8, out_instr;
    logic [DW-1:0] in_data, out_data;
    logic [31:0]   bubble_cnt;

    logic          d4_in_ready, d4_out_valid;
    logic [31:0]   d4_pc, d4_pc4, d4_pc8, d4_instr;
    logic [DW-1:0] d4_data;
    logic [3:0]    bubble_cnt4;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .PC_RESET(PCR), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_pc4(in_pc4), .in_pc8(in_pc8), .in_instr(in_instr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_pc4(out_pc4), .out_pc8(out_pc8), .out_instr(out_instr), .out_data(out_data),
        .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter instance, used only for the saturation behaviour.
    pipe_stage_elastic #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES), .PC_RESET(PCR), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(d4_in_ready),
        .in_pc(in_pc), .in_pc4(in_pc4), .in_pc8(in_pc8), .in_instr(in_instr), .in_data(in_data),
        .out_valid(d4_out_valid), .out_ready(out_ready),
        .out_pc(d4_pc), .out_pc4(d4_pc4), .out_pc8(d4_pc8), .out_instr(d4_instr), .out_data(d4_data),
        .bubble_cnt(bubble_cnt4)
    );

    bundle_t     exp_q[$];
    bundle_t     mon_b;
    int          occ  = 0;
    longint      bub  = 0;
    int          bub4 = 0;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_bundle(input logic [31:0] pc);
        in_pc    = pc;
        in_pc4   = pc + 32'd4;
        in_pc8   = pc + 32'd8;
        in_instr = $urandom | 32'h1;   // never a nop, so a zero instr means "killed"
        for (int i = 0; i < NUM_LANES; i++) in_data[i*DATA_W +: DATA_W] = $urandom;
    endtask

    // One clock: drive inputs, advance the reference model at the edge, check flags after it.
    task automatic step(input logic r, input logic f, input logic iv, input logic ordy,
                        input logic [31:0] pc);
        bit      ofire, ifire;
        bundle_t nb;
        reset = r; flush = f; in_valid = iv; out_ready = ordy;
        set_bundle(pc);
        @(posedge clk);
        if (r) begin
            occ = 0; exp_q.delete(); bub = 0; bub4 = 0;
        end else begin
            if (occ == 0) begin
                if (bub != 64'hFFFF_FFFF) bub++;
                if (bub4 != 15) bub4++;
            end
            if (f) begin
                occ = 0;
                exp_q.delete();
            end else begin
                ofire = (occ > 0) && ordy;
                ifire = iv && (occ < 2);
                if (ifire) begin
                    nb.pc = in_pc; nb.pc4 = in_pc4; nb.pc8 = in_pc8;
                    nb.instr = in_instr; nb.data = in_data;
                    exp_q.push_back(nb);
                end
                occ = occ - int'(ofire) + int'(ifire);
            end
        end
        #1;
        chk("out_valid", out_valid, occ > 0);
        chk("in_ready", in_ready, occ < 2);
        chk("bubble_cnt", bubble_cnt, bub);
        chk("bubble_cnt4", bubble_cnt4, bub4);
        if (occ == 0) chk("nop_when_empty", out_instr, 32'h0);
    endtask

    // Scoreboard monitor: every output transfer must match the oldest expected bundle.
    always @(negedge clk) begin
        if (!reset && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_output: got pc %0h, expected no bundle", out_pc);
            end else begin
                mon_b = exp_q.pop_front();
                chk("out_pc",    out_pc,    mon_b.pc);
                chk("out_pc4",   out_pc4,   mon_b.pc4);
                chk("out_pc8",   out_pc8,   mon_b.pc8);
                chk("out_instr", out_instr, mon_b.instr);
                chk("out_data",  out_data,  mon_b.data);
            end
        end
    end

    initial begin
        // Reset held two cycles.
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        chk("rst_out_pc",   out_pc,   PCR);
        chk("rst_out_pc4",  out_pc4,  PCR);
        chk("rst_out_pc8",  out_pc8,  PCR);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_instr", out_instr, 32'h0);

        // Idle: counter counts every empty cycle, narrow one saturates.
        repeat (10) step(0, 0, 0, 1, $urandom);
        chk("bubble_after_10_idle", bubble_cnt, 10);
        repeat (10) step(0, 0, 0, 1, $urandom);
        chk("bubble4_saturated", bubble_cnt4, 15);

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, PCR + 32'(4 * i));
        step(0, 0, 0, 1, $urandom);
        step(0, 0, 0, 1, $urandom);

        // Back-pressure mid-stream, then release.
        step(0, 0, 1, 1, 32'h0000_4000);
        step(0, 0, 1, 0, 32'h0000_4004);
        chk("bp_in_ready_low", in_ready, 1'b0);
        step(0, 0, 1, 0, 32'h0000_4008);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 32'h0000_400C + 32'(4 * i));
        step(0, 0, 0, 1, $urandom);
        step(0, 0, 0, 1, $urandom);

        // Flush with both entries full and a bundle offered.
        step(0, 0, 1, 0, 32'h0000_5000);
        step(0, 0, 1, 0, 32'h0000_5004);
        chk("skid_full_in_ready", in_ready, 1'b0);
        step(0, 1, 1, 1, 32'h0000_5008);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_out_instr", out_instr, 32'h0);
        chk("flush_in_ready",  in_ready,  1'b1);
        step(0, 0, 0, 1, $urandom);

        // Random traffic with occasional flushes.
        repeat (400)
            step(0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) != 0, $urandom);

        // Reset with both entries full.
        step(0, 0, 0, 1, $urandom);
        step(0, 0, 0, 1, $urandom);
        step(0, 0, 1, 0, 32'h0000_6000);
        step(0, 0, 1, 0, 32'h0000_6004);
        step(1, 0, 1, 1, 32'h0000_6008);
        chk("rst2_out_pc",    out_pc,    PCR);
        chk("rst2_out_pc8",   out_pc8,   PCR);
        chk("rst2_out_data",  out_data,  '0);
        chk("rst2_out_instr", out_instr, 32'h0);
        chk("rst2_out_valid", out_valid, 1'b0);
        chk("rst2_in_ready",  in_ready,  1'b1);
        chk("rst2_bubble",    bubble_cnt, 0);

        step(0, 0, 1, 1, 32'h0000_7000);
        repeat (3) step(0, 0, 0, 1, $urandom);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
